// File: rtl/vu_level_meter.sv
// vu_level_meter: turns the UART sample stream into bar-graph quantities
// for the VGA renderer. Produces an instant-attack / linear-decay level bar,
// a peak-hold marker that never sits below the bar, and a one-cycle
// change strobe so the renderer knows when to re-latch.
//
// Optional feature macro: CLIP_INDICATOR_EN
//   defined     -> clip output pulses high for hold_cycles after each
//                  full-scale sample
//   not defined -> clip is tied low and no clip counter is built
//
// Peak FSM states:
//   state    | meaning
//   ST_HOLD  | peak was just loaded; hold counter running down
//   ST_DECAY | peak steps down one segment per decay tick toward level
module vu_level_meter #(
    parameter int data_width   = 8,
    parameter int bar_segments = 16,
    parameter int hold_cycles  = 64,
    parameter int decay_cycles = 8,
    localparam int SEG_W       = $clog2(bar_segments + 1)
) (
    input  logic                  clk_board,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [data_width-1:0] data_in,
    input  logic                  data_valid,
    output logic [SEG_W-1:0]      level,
    output logic [SEG_W-1:0]      peak,
    output logic                  changed,
    output logic                  clip
);

    localparam int PROD_W = data_width + SEG_W;
    localparam int HOLD_W = (hold_cycles > 1) ? $clog2(hold_cycles) : 1;
    localparam int DEC_W  = (decay_cycles > 1) ? $clog2(decay_cycles) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(hold_cycles - 1);
    localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(decay_cycles - 1);

    typedef enum logic {
        ST_HOLD,
        ST_DECAY
    } state_t;

    state_t              state_q, state_d;
    logic [SEG_W-1:0]    level_q, level_d;
    logic [SEG_W-1:0]    peak_q, peak_d;
    logic [SEG_W-1:0]    target_q, target_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [DEC_W-1:0]    dec_cnt_q;
    logic                changed_q;
    logic                accept;
    logic                tick;
    logic [PROD_W-1:0]   prod;
    logic [SEG_W-1:0]    seg;

    // A sample only counts while the block is running; frozen cycles drop it.
    assign accept = enable & data_valid;
    assign tick   = enable && (dec_cnt_q == DEC_LAST);

    // Ceiling map of the sample onto segments, so any nonzero input lights
    // at least one segment and full scale lands exactly on bar_segments.
    assign prod = ({{SEG_W{1'b0}}, data_in} * PROD_W'(bar_segments))
                + PROD_W'((1 << data_width) - 1);
    assign seg  = prod[PROD_W-1:data_width];

    // Free-running decay timer, paused while disabled.
    always_ff @(posedge clk_board or negedge reset) begin
        if (!reset) begin
            dec_cnt_q <= '0;
        end else if (enable) begin
            dec_cnt_q <= (dec_cnt_q == DEC_LAST) ? '0 : dec_cnt_q + DEC_W'(1);
        end
    end

    // Next-state for target, level and the peak-hold FSM.
    always_comb begin
        target_d   = accept ? seg : target_q;
        level_d    = level_q;
        peak_d     = peak_q;
        hold_cnt_d = hold_cnt_q;
        state_d    = state_q;

        // Attack wins over decay; decay chases the freshly updated target.
        if (accept && (seg >= level_q)) begin
            level_d = seg;
        end else if (tick && (level_q > target_d)) begin
            level_d = level_q - SEG_W'(1);
        end

        if (enable) begin
            if (level_d > peak_q) begin
                peak_d     = level_d;
                hold_cnt_d = HOLD_LOAD;
                state_d    = ST_HOLD;
            end else begin
                case (state_q)
                    ST_HOLD: begin
                        if (hold_cnt_q == '0) begin
                            state_d = ST_DECAY;
                        end else begin
                            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                        end
                    end
                    ST_DECAY: begin
                        // peak stays >= level_d because it only steps when strictly above it.
                        if (tick && (peak_q > level_d)) begin
                            peak_d = peak_q - SEG_W'(1);
                        end
                    end
                    default: state_d = ST_DECAY;
                endcase
            end
        end
    end

    // Peak FSM state register.
    always_ff @(posedge clk_board or negedge reset) begin
        if (!reset) begin
            state_q <= ST_DECAY;
        end else if (enable) begin
            state_q <= state_d;
        end
    end

    // Datapath registers; changed is cleared rather than held when frozen.
    always_ff @(posedge clk_board or negedge reset) begin
        if (!reset) begin
            level_q    <= '0;
            peak_q     <= '0;
            target_q   <= '0;
            hold_cnt_q <= '0;
            changed_q  <= 1'b0;
        end else begin
            changed_q <= enable && ((level_d != level_q) || (peak_d != peak_q));
            if (enable) begin
                level_q    <= level_d;
                peak_q     <= peak_d;
                target_q   <= target_d;
                hold_cnt_q <= hold_cnt_d;
            end
        end
    end

`ifdef CLIP_INDICATOR_EN
    logic [HOLD_W-1:0] clip_cnt_q;
    logic              clip_q;
    logic              full_scale;

    assign full_scale = accept && (data_in == {data_width{1'b1}});

    // Clip indicator: retriggerable one-shot of hold_cycles per full-scale sample.
    always_ff @(posedge clk_board or negedge reset) begin
        if (!reset) begin
            clip_q     <= 1'b0;
            clip_cnt_q <= '0;
        end else if (enable) begin
            if (full_scale) begin
                clip_q     <= 1'b1;
                clip_cnt_q <= HOLD_LOAD;
            end else if (clip_q) begin
                if (clip_cnt_q == '0) begin
                    clip_q <= 1'b0;
                end else begin
                    clip_cnt_q <= clip_cnt_q - HOLD_W'(1);
                end
            end
        end
    end

    assign clip = clip_q;
`else
    assign clip = 1'b0;
`endif

    assign level   = level_q;
    assign peak    = peak_q;
    assign changed = changed_q;

endmodule
